// File: rtl/vermicom_tx_scheduler.sv
// vermicom_tx_scheduler: shares one Vermicom UART transmitter between NUM_REQ
// byte producers. Programs DIVISION once after reset, then per byte:
// round-robin grant, DATA write, STATUS poll until tx_event_flag, W1C clear.
// Optional poll timeout: define VERMICOM_TX_SCHEDULER_TIMEOUT_EN.
module vermicom_tx_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter logic [31:0] BASE_ADDRESS   = 32'h0,
  parameter logic [31:0] DIVISION       = 32'd433,
  parameter int unsigned TX_EVENT_BIT   = 0,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       bus_valid,
  input  logic                       bus_ready,
  output logic [31:0]                bus_address,
  output logic [3:0]                 bus_wstrobe,
  output logic [31:0]                bus_wdata,
  input  logic [31:0]                bus_rdata,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       error
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  localparam logic [31:0] ADDR_STATUS   = BASE_ADDRESS + 32'd4;
  localparam logic [31:0] ADDR_DIVISION = BASE_ADDRESS + 32'd8;
  localparam logic [31:0] ADDR_DATA     = BASE_ADDRESS + 32'd12;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SEND,
    ST_POLL,
    ST_CLEAR
  } state_t;

  state_t           state, state_nxt;
  logic             armed;
  logic [IDX_W-1:0] rr_ptr, rr_nxt;
  logic [IDX_W-1:0] owner_nxt;
  logic [7:0]       byte_buf, byte_nxt;

  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic [7:0]       grant_byte;
  int unsigned      cand;

  logic             done;
  logic             tx_event;
  logic             timeout_hit;

  // armed is low while in reset so the bus stays quiet; INIT issues on the
  // first clock after release.
  assign busy      = armed && (state != ST_IDLE);
  assign bus_valid = busy;
  assign done      = bus_valid && bus_ready;
  assign tx_event  = bus_rdata[TX_EVENT_BIT];

`ifdef VERMICOM_TX_SCHEDULER_TIMEOUT_EN
  logic [31:0] poll_cnt;
  logic        error_q;
  logic        unused_rdata;

  // Timeout only fires on a completed read so an in-flight request is never withdrawn.
  assign timeout_hit = (state == ST_POLL) && done && !tx_event &&
                       (poll_cnt >= TIMEOUT_CYCLES - 32'd1);
  assign error        = error_q;
  assign unused_rdata = ^bus_rdata;

  // Poll-cycle counter (zero outside POLL) and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      poll_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      if (state != ST_POLL) poll_cnt <= '0;
      else                  poll_cnt <= poll_cnt + 32'd1;
      if (timeout_hit) error_q <= 1'b1;
    end
  end
`else
  logic unused_rdata;

  assign timeout_hit  = 1'b0;
  assign error        = 1'b0;
  assign unused_rdata = ^{bus_rdata, TIMEOUT_CYCLES};
`endif

  // Round-robin search: first requester after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_byte  = '0;
    cand        = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!grant_found && (cand == i) && req_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = IDX_W'(i);
        end
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) grant_byte = req_data[8*i +: 8];
    end
  end

  // State, round-robin pointer, owner and byte buffer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_INIT;
      armed    <= 1'b0;
      rr_ptr   <= IDX_W'(NUM_REQ - 1);
      owner    <= '0;
      byte_buf <= '0;
    end else begin
      state    <= state_nxt;
      armed    <= 1'b1;
      rr_ptr   <= rr_nxt;
      owner    <= owner_nxt;
      byte_buf <= byte_nxt;
    end
  end

  // Next-state and bus command decode; command depends only on state so it
  // stays stable while the UART stalls.
  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr_ptr;
    owner_nxt   = owner;
    byte_nxt    = byte_buf;
    bus_address = '0;
    bus_wstrobe = '0;
    bus_wdata   = '0;
    req_ready   = '0;
    if (armed) begin
      unique case (state)
        ST_INIT: begin
          bus_address = ADDR_DIVISION;
          bus_wstrobe = 4'hF;
          bus_wdata   = DIVISION;
          if (done) state_nxt = ST_IDLE;
        end
        ST_IDLE: begin
          if (grant_found) begin
            owner_nxt = grant_idx;
            byte_nxt  = grant_byte;
            state_nxt = ST_SEND;
          end
        end
        ST_SEND: begin
          bus_address = ADDR_DATA;
          bus_wstrobe = 4'h1;
          bus_wdata   = {24'h0, byte_buf};
          if (done) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
              req_ready[i] = (owner == IDX_W'(i));
            end
            rr_nxt    = owner;
            state_nxt = ST_POLL;
          end
        end
        ST_POLL: begin
          bus_address = ADDR_STATUS;
          bus_wstrobe = 4'h0;
          if ((done && tx_event) || timeout_hit) state_nxt = ST_CLEAR;
        end
        ST_CLEAR: begin
          bus_address = ADDR_STATUS;
          bus_wstrobe = 4'hF;
          bus_wdata   = 32'h1 << TX_EVENT_BIT;
          if (done) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule
